mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the CPU's single memory port between instruction fetch and the data (LW/SW) stage. It sits between the datapath and the memory interface. Each request is latched, driven onto the port, and held until the memory acknowledges it; the requester then gets a one-cycle ack with registered read data. Data accesses win ties. A streak counter bounds how long a pending fetch can be starved.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending; must be ≥1
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; level, held with i_addr until i_ack
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word; valid when i_ack=1, held afterwards
- i_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; level, held with d_wr/d_addr/d_wdata/d_wstrb until d_ack
- d_wr  in  1  1=store (SW), 0=load (LW)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wstrb  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load word; valid when d_ack=1, updated only on loads
- d_ack  out  1  one-cycle completion pulse for data
- m_req  out  1  memory request, held until m_ack
- m_wr, m_addr, m_wdata, m_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  latched copy of the granted request; m_wr=0 and m_wstrb=0 for fetch
- m_rdata  in  DATA_W  memory read data, valid with m_ack
- m_ack  in  1  memory completion, may arrive in any cycle m_req=1
- busy  out  1  1 whenever state ≠ IDLE

## Operation
- The FSM has four states: IDLE, INST, DATA, DONE.
- IDLE
  - d_req only → DATA.
  - i_req only → INST.
  - Both high → INST if streak==MAX_D_STREAK, else DATA.
  - Neither high → stay in IDLE.
  - On grant, the request fields are latched into the m_* registers.
- INST/DATA
  - m_req=1.
  - m_ack=1 → DONE, and the winner's rdata is latched from m_rdata. Loads and fetches latch; stores do not.
  - m_ack=0 → stay.
- DONE
  - The winner's ack=1 and m_req=0.
  - Next state is always IDLE.
  - m_ack is ignored in DONE and in IDLE.
- Streak counter, width $clog2(MAX_D_STREAK+1), updated on grants only:
  - Data grant with i_req=1 → +1, saturating at MAX_D_STREAK.
  - Data grant with i_req=0 → 0.
  - Inst grant → 0.
- Requester contract
  - Fields must stay stable while req=1 until ack.
  - req still high in the cycle after ack is treated as a new request.
  - Requester-side fields are not sampled after grant.
- The arbiter drives no write-back or stall decisions. The pipeline stalls on req && !ack.

## Timing
- Reset
  - State IDLE, streak 0.
  - m_req, m_wr, i_ack, d_ack, busy = 0.
  - m_addr, m_wdata, m_wstrb, i_rdata, d_rdata = 0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Latency: req seen in IDLE cycle N → m_req in N+1 → m_ack at cycle M ≥ N+1 → ack in M+1. Minimum req-to-ack is 2 cycles.
- Back-to-back accesses to the port are spaced 3 cycles at minimum: grant, access, done.
- A request arriving while busy waits and is evaluated in the next IDLE cycle.
- rst during INST/DATA drops m_req the next cycle with no ack issued. A late m_ack after reset is ignored.
- m_ack with m_req=0 is ignored.

## Test plan
- **Fetch alone:** i_req=1, i_addr=0xBFC00000, m_ack in the first m_req cycle with m_rdata=0x3C080001 → m_addr=0xBFC00000, m_wr=0, i_ack exactly 2 cycles after i_req, i_rdata=0x3C080001, busy low the following cycle.
- **Store with wait states:** d_req=1, d_wr=1, d_addr=0x80000010, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, m_ack after 3 m_req cycles → m_* fields match and are held all 3 cycles, d_ack 1 cycle after m_ack, d_rdata unchanged.
- **Tie and starvation bound, MAX_D_STREAK=4:** i_req and d_req both held high, each d_ack followed by a fresh data request → 4 data grants, then 1 inst grant, then streak 0 and data wins again.
- **Back-to-back fetches:** i_req held high across ack with two different addresses → two m_req phases, with a single IDLE cycle between DONE and the next grant.
- **Reset mid-access:** rst for 1 cycle while in DATA, then m_ack=1 one cycle later → no d_ack, m_req=0 after the reset edge, all outputs at reset values.
- **Spurious m_ack:** m_ack=1 while IDLE → no ack, no state change, rdata registers unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the fetch, data and memory-port signals around the
//                memory port arbiter.
//                  i_*  fetch requester (req/addr in, rdata/ack out)
//                  d_*  data requester  (req/wr/addr/wdata/wstrb in,
//                                        rdata/ack out)
//                  m_*  memory port     (req/wr/addr/wdata/wstrb out,
//                                        rdata/ack in)
//                  busy arbiter not idle
//                The slave modport is the arbiter's view; the master modport
//                is the view of the datapath plus memory around it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              m_req;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;

    logic              busy;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack,
        input  d_req, d_wr, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_ack,
        output m_req, m_wr, m_addr, m_wdata, m_wstrb,
        input  m_rdata, m_ack,
        output busy
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack,
        output d_req, d_wr, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_ack,
        input  m_req, m_wr, m_addr, m_wdata, m_wstrb,
        output m_rdata, m_ack,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one memory port between instruction fetch and the
//                data (load/store) stage. A granted request is latched onto
//                the port and held until the memory acknowledges it; the
//                requester then sees a one-cycle ack with registered read
//                data. Data wins ties, but a streak counter forces a pending
//                fetch through after MAX_D_STREAK consecutive data grants.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - mem_port_arbiter_if.slave (fetch, data, memory, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] c_streak_max = STREAK_W'(MAX_D_STREAK);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_inst = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [STREAK_W-1:0] streak;
    logic                sel_data;     // winner of the access in flight
    logic                grant_inst;
    logic                grant_data;

    // ------------------------------------------------------------------
    // Arbitration decode; only acted on in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        grant_inst = bus.i_req && (!bus.d_req || (streak == c_streak_max));
        grant_data = bus.d_req && !grant_inst;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= c_st_idle;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            c_st_idle: begin
                if (grant_inst) begin
                    state_next = c_st_inst;
                end else if (grant_data) begin
                    state_next = c_st_data;
                end
            end
            c_st_inst,
            c_st_data: begin
                if (bus.m_ack) begin
                    state_next = c_st_done;
                end
            end
            c_st_done: begin
                state_next = c_st_idle;
            end
            default: begin
                state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state (and the registered winner) only, so no
    // input reaches an output combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        bus.m_req = (state == c_st_inst) || (state == c_st_data);
        bus.i_ack = (state == c_st_done) && !sel_data;
        bus.d_ack = (state == c_st_done) && sel_data;
        bus.busy  = (state != c_st_idle);
    end

    // ------------------------------------------------------------------
    // Port latch, read-data capture and streak counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.m_wr    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.m_wstrb <= '0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
            streak      <= '0;
            sel_data    <= 1'b0;
        end else begin
            case (state)
                c_st_idle: begin
                    if (grant_inst) begin
                        bus.m_wr    <= 1'b0;
                        bus.m_addr  <= bus.i_addr;
                        bus.m_wstrb <= '0;
                        sel_data    <= 1'b0;
                        streak      <= '0;
                    end else if (grant_data) begin
                        bus.m_wr    <= bus.d_wr;
                        bus.m_addr  <= bus.d_addr;
                        bus.m_wdata <= bus.d_wdata;
                        bus.m_wstrb <= bus.d_wstrb;
                        sel_data    <= 1'b1;
                        // Only a data grant that overtook a waiting fetch
                        // counts toward the starvation bound.
                        if (bus.i_req) begin
                            streak <= (streak == c_streak_max) ? streak
                                                               : streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                c_st_inst: begin
                    if (bus.m_ack) begin
                        bus.i_rdata <= bus.m_rdata;
                    end
                end
                c_st_data: begin
                    // Stores leave the load-data register untouched.
                    if (bus.m_ack && !bus.m_wr) begin
                        bus.d_rdata <= bus.m_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter: directed scenarios
//                plus a randomized run against a transaction-level model of
//                the arbitration and read-data rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int MAX_D_STREAK = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_D_STREAK(MAX_D_STREAK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_streak;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_wr    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wstrb = '0;
        bus.m_rdata = '0;
        bus.m_ack   = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        m_streak    = 0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.m_req, bus.m_wr, bus.i_ack, bus.d_ack, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {bus.m_req, bus.m_wr, bus.i_ack, bus.d_ack, bus.busy});
        end
        checks++;
        if ({bus.m_addr, bus.m_wdata, bus.m_wstrb} !== 68'h0) begin
            errors++;
            $display("FAIL reset_mfields got %0h want 0",
                     {bus.m_addr, bus.m_wdata, bus.m_wstrb});
        end
        checks++;
        if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata got %0h want 0", {bus.i_rdata, bus.d_rdata});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b want 0", bus.busy);
        end
        m_streak    = 0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_fetch_alone();
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'hBFC0_0000;
        tick();
        checks++;
        if ({bus.m_req, bus.m_wr, bus.m_wstrb, bus.i_ack} !== 7'b1_0_0000_0 ||
            bus.m_addr !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL fetch_grant req/wr/strb/ack got %b addr %0h want 1000000 addr bfc00000",
                     {bus.m_req, bus.m_wr, bus.m_wstrb, bus.i_ack}, bus.m_addr);
        end
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h3C08_0001;
        tick();
        checks++;
        if ({bus.i_ack, bus.d_ack, bus.m_req} !== 3'b100 ||
            bus.i_rdata !== 32'h3C08_0001) begin
            errors++;
            $display("FAIL fetch_ack ack/dack/mreq got %b rdata %0h want 100 rdata 3c080001",
                     {bus.i_ack, bus.d_ack, bus.m_req}, bus.i_rdata);
        end
        bus.i_req   = 1'b0;
        bus.m_ack   = 1'b0;
        bus.m_rdata = '0;
        exp_i_rdata = 32'h3C08_0001;
        tick();
        checks++;
        if ({bus.busy, bus.i_ack} !== 2'b00 || bus.i_rdata !== exp_i_rdata) begin
            errors++;
            $display("FAIL fetch_after busy/ack got %b rdata %0h want 00 rdata %0h",
                     {bus.busy, bus.i_ack}, bus.i_rdata, exp_i_rdata);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_store_wait();
        do_reset();
        bus.d_req   = 1'b1;
        bus.d_wr    = 1'b1;
        bus.d_addr  = 32'h8000_0010;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_wstrb = 4'b0011;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bus.m_req, bus.m_wr, bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.d_ack} !==
                {1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 1'b0}) begin
                errors++;
                $display("FAIL store_hold cyc %0d got req %b wr %b addr %0h wdata %0h strb %b dack %b",
                         k, bus.m_req, bus.m_wr, bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.d_ack);
            end
            if (k == 2) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = 32'h1234_5678;
            end
            tick();
        end
        checks++;
        if ({bus.d_ack, bus.i_ack, bus.m_req} !== 3'b100 || bus.d_rdata !== exp_d_rdata) begin
            errors++;
            $display("FAIL store_ack dack/iack/mreq got %b rdata %0h want 100 rdata %0h",
                     {bus.d_ack, bus.i_ack, bus.m_req}, bus.d_rdata, exp_d_rdata);
        end
        bus.d_req = 1'b0;
        bus.m_ack = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL store_after busy got %b want 0", bus.busy);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_starvation();
        // Grant g is data when bit g is set: D D D D I D
        logic [5:0]  want_d;
        logic [31:0] ia;
        logic [31:0] da;
        want_d = 6'b101111;
        do_reset();
        ia = 32'h0000_1000;
        da = 32'h0000_2000;
        bus.i_req  = 1'b1;
        bus.i_addr = ia;
        bus.d_req  = 1'b1;
        bus.d_wr   = 1'b0;
        bus.d_addr = da;
        for (int g = 0; g < 6; g++) begin
            tick();
            checks++;
            if (bus.m_req !== 1'b1 || bus.m_addr !== (want_d[g] ? da : ia)) begin
                errors++;
                $display("FAIL starve_grant %0d got req %b addr %0h want req 1 addr %0h",
                         g, bus.m_req, bus.m_addr, want_d[g] ? da : ia);
            end
            bus.m_ack   = 1'b1;
            bus.m_rdata = 32'hA000_0000 + 32'(g);
            tick();
            checks++;
            if ({bus.i_ack, bus.d_ack} !== (want_d[g] ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL starve_ack %0d got %b want %b",
                         g, {bus.i_ack, bus.d_ack}, want_d[g] ? 2'b01 : 2'b10);
            end
            bus.m_ack = 1'b0;
            if (g == 5) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end else if (want_d[g]) begin
                da          = da + 32'd4;
                bus.d_addr  = da;
            end else begin
                ia          = ia + 32'd4;
                bus.i_addr  = ia;
            end
            tick();
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL starve_idle %0d busy got %b want 0", g, bus.busy);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        do_reset();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0040_0000;
        tick();
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h0040_0000) begin
            errors++;
            $display("FAIL b2b_first got req %b addr %0h want 1 00400000", bus.m_req, bus.m_addr);
        end
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h1111_1111;
        tick();
        bus.m_ack  = 1'b0;
        bus.i_addr = 32'h0040_0004;
        tick();
        checks++;
        if ({bus.busy, bus.m_req} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_gap busy/mreq got %b want 00", {bus.busy, bus.m_req});
        end
        tick();
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h0040_0004) begin
            errors++;
            $display("FAIL b2b_second got req %b addr %0h want 1 00400004", bus.m_req, bus.m_addr);
        end
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h2222_2222;
        tick();
        checks++;
        if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'h2222_2222) begin
            errors++;
            $display("FAIL b2b_ack got ack %b rdata %0h want 1 22222222", bus.i_ack, bus.i_rdata);
        end
        bus.i_req = 1'b0;
        bus.m_ack = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_spurious();
        do_reset();
        bus.d_req  = 1'b1;
        bus.d_wr   = 1'b0;
        bus.d_addr = 32'h0000_0040;
        tick();
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hCAFE_F00D;
        tick();
        bus.d_req   = 1'b0;
        bus.m_ack   = 1'b0;
        exp_d_rdata = 32'hCAFE_F00D;
        tick();
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.busy, bus.m_req, bus.i_ack, bus.d_ack} !== 4'b0 ||
                bus.d_rdata !== exp_d_rdata || bus.i_rdata !== exp_i_rdata) begin
                errors++;
                $display("FAIL spurious cyc %0d ctrl %b drd %0h ird %0h want 0000 %0h %0h",
                         k, {bus.busy, bus.m_req, bus.i_ack, bus.d_ack},
                         bus.d_rdata, bus.i_rdata, exp_d_rdata, exp_i_rdata);
            end
        end
        bus.m_ack = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        do_reset();
        bus.d_req   = 1'b1;
        bus.d_wr    = 1'b0;
        bus.d_addr  = 32'h0000_0080;
        bus.d_wdata = 32'h5555_AAAA;
        bus.d_wstrb = 4'hF;
        tick();
        checks++;
        if (bus.m_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre mreq got %b want 1", bus.m_req);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.m_req, bus.m_wr, bus.i_ack, bus.d_ack, bus.busy} !== 5'b0 ||
            {bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.i_rdata, bus.d_rdata} !== 132'h0) begin
            errors++;
            $display("FAIL rstmid_reset ctrl %b addr %0h wdata %0h strb %0h want all 0",
                     {bus.m_req, bus.m_wr, bus.i_ack, bus.d_ack, bus.busy},
                     bus.m_addr, bus.m_wdata, bus.m_wstrb);
        end
        rst         = 1'b0;
        bus.d_req   = 1'b0;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'h7777_7777;
        tick();
        checks++;
        if ({bus.d_ack, bus.i_ack, bus.busy, bus.m_req} !== 4'b0 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_late ctrl %b drd %0h want 0000 0",
                     {bus.d_ack, bus.i_ack, bus.busy, bus.m_req}, bus.d_rdata);
        end
        bus.m_ack = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Randomized traffic against a transaction-level model: pending
    // requests per requester, winner chosen from the tie/streak rule.
    // ------------------------------------------------------------------
    task automatic test_random();
        bit          ip, dp, dw, win_d, ip_g;
        logic [31:0] ia, da, dd, rd;
        logic [3:0]  ds;
        int          waits;
        do_reset();
        ip = 1'b0;
        dp = 1'b0;
        ia = '0; da = '0; dd = '0; ds = '0; dw = 1'b0;
        for (int r = 0; r < 80; r++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1'b1;
                ia = $urandom;
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1'b1;
                dw = 1'($urandom_range(0, 1));
                da = $urandom;
                dd = $urandom;
                ds = 4'($urandom);
            end
            if (!ip && !dp) begin
                ip = 1'b1;
                ia = $urandom;
            end
            bus.i_req = ip;  bus.i_addr = ia;
            bus.d_req = dp;  bus.d_wr = dw; bus.d_addr = da;
            bus.d_wdata = dd; bus.d_wstrb = ds;

            win_d = dp && !(ip && m_streak == MAX_D_STREAK);
            ip_g  = ip;
            tick();
            checks++;
            if (win_d) begin
                if ({bus.m_req, bus.m_wr, bus.m_addr, bus.m_wdata, bus.m_wstrb} !==
                    {1'b1, dw, da, dd, ds}) begin
                    errors++;
                    $display("FAIL rand_dgrant %0d got req %b wr %b addr %0h wd %0h strb %0h want 1 %b %0h %0h %0h",
                             r, bus.m_req, bus.m_wr, bus.m_addr, bus.m_wdata, bus.m_wstrb, dw, da, dd, ds);
                end
            end else begin
                if ({bus.m_req, bus.m_wr, bus.m_addr, bus.m_wstrb} !== {1'b1, 1'b0, ia, 4'h0}) begin
                    errors++;
                    $display("FAIL rand_igrant %0d got req %b wr %b addr %0h strb %0h want 1 0 %0h 0",
                             r, bus.m_req, bus.m_wr, bus.m_addr, bus.m_wstrb, ia);
                end
            end

            waits = $urandom_range(0, 3);
            for (int w = 0; w < waits; w++) begin
                // A new request raised mid-access must wait for IDLE.
                if (win_d && !ip && $urandom_range(0, 1) == 1) begin
                    ip = 1'b1; ia = $urandom;
                    bus.i_req = ip; bus.i_addr = ia;
                end
                tick();
                checks++;
                if ({bus.m_req, bus.i_ack, bus.d_ack} !== 3'b100) begin
                    errors++;
                    $display("FAIL rand_wait %0d.%0d got %b want 100",
                             r, w, {bus.m_req, bus.i_ack, bus.d_ack});
                end
            end

            rd = $urandom;
            bus.m_ack   = 1'b1;
            bus.m_rdata = rd;
            tick();
            if (win_d) begin
                if (!dw) exp_d_rdata = rd;
                m_streak = ip_g ? ((m_streak + 1 > MAX_D_STREAK) ? MAX_D_STREAK : m_streak + 1) : 0;
                dp = 1'b0;
            end else begin
                exp_i_rdata = rd;
                m_streak    = 0;
                ip          = 1'b0;
            end
            checks++;
            if ({bus.i_ack, bus.d_ack, bus.m_req} !== {!win_d, win_d, 1'b0} ||
                bus.i_rdata !== exp_i_rdata || bus.d_rdata !== exp_d_rdata) begin
                errors++;
                $display("FAIL rand_ack %0d got ack %b ird %0h drd %0h want %b %0h %0h",
                         r, {bus.i_ack, bus.d_ack, bus.m_req}, bus.i_rdata, bus.d_rdata,
                         {!win_d, win_d, 1'b0}, exp_i_rdata, exp_d_rdata);
            end
            bus.m_ack   = 1'b0;
            bus.m_rdata = $urandom;
            bus.i_req   = ip;
            bus.d_req   = dp;
            tick();
            checks++;
            if ({bus.busy, bus.m_req} !== 2'b00) begin
                errors++;
                $display("FAIL rand_idle %0d got %b want 00", r, {bus.busy, bus.m_req});
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_fetch_alone();
        test_store_wait();
        test_starvation();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
